// File: rtl/ows_pkg.sv
// Shared definitions for the output write sequencer: state encoding and
// the width helper used to size the channel and hold counters.
package ows_pkg;

  typedef enum logic [1:0] {
    OWS_IDLE  = 2'd0,
    OWS_WRITE = 2'd1,
    OWS_HOLD  = 2'd2,
    OWS_DRAIN = 2'd3
  } ows_state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/ows_counter.sv
// Up-counter with synchronous clear (priority over enable) and a flag that
// reports when the count equals a caller-supplied terminal value.
module ows_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  // Count register: clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/output_write_sequencer.sv
// Turns a PE-array done level into one masked write per output channel,
// followed by a quiet hold interval and a wait for done to drop.
module output_write_sequencer
  import ows_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 5,
  parameter int CH_W        = clog2_min1(NUM_CH),
  parameter int HOLD_W      = clog2_min1(HOLD_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done,
  input  logic              ready,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              stall_clr,
  output logic              w_en,
  output logic [CH_W-1:0]   w_ch,
  output logic              stall,
  output logic              busy,
  output logic              burst_done
);

  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  ows_state_t        state_r;
  ows_state_t        state_next_s;
  logic [NUM_CH-1:0] mask_r;
  logic [CH_W-1:0]   ch_cnt_s;
  logic              ch_last_s;
  logic [HOLD_W-1:0] hold_cnt_s;
  logic              hold_last_s;
  logic              ch_on_s;
  logic              advance_s;
  logic              capture_s;
  logic              ch_clr_s;
  logic              ch_en_s;
  logic              hold_clr_s;
  logic              hold_en_s;
  logic              unused_hold_s;

  assign ch_on_s       = mask_r[ch_cnt_s];
  assign unused_hold_s = ^hold_cnt_s;

  ows_counter #(.W(CH_W)) u_ch_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ch_clr_s),
    .en      (ch_en_s),
    .term    (CH_LAST),
    .cnt     (ch_cnt_s),
    .at_term (ch_last_s)
  );

  ows_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (hold_clr_s),
    .en      (hold_en_s),
    .term    (HOLD_LAST),
    .cnt     (hold_cnt_s),
    .at_term (hold_last_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= OWS_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Channel mask is frozen when a done event is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r <= '0;
    end else if (capture_s) begin
      mask_r <= ch_mask;
    end
  end

  // Next-state, counter control and output decode.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    advance_s    = 1'b0;
    ch_clr_s     = 1'b0;
    ch_en_s      = 1'b0;
    hold_clr_s   = 1'b0;
    hold_en_s    = 1'b0;
    w_en         = 1'b0;
    w_ch         = '0;
    stall        = 1'b0;
    busy         = 1'b1;
    burst_done   = 1'b0;
    case (state_r)
      OWS_IDLE: begin
        busy  = 1'b0;
        stall = done & ~stall_clr;
        if (done) begin
          capture_s    = 1'b1;
          ch_clr_s     = 1'b1;
          state_next_s = OWS_WRITE;
        end else begin
          state_next_s = OWS_IDLE;
        end
      end
      OWS_WRITE: begin
        w_ch      = ch_cnt_s;
        w_en      = ready & ch_on_s;
        stall     = ~stall_clr;
        // A masked-off channel retires in one cycle regardless of ready.
        advance_s = ready | ~ch_on_s;
        if (advance_s && ch_last_s) begin
          burst_done = 1'b1;
          ch_clr_s   = 1'b1;
          if (HOLD_CYCLES > 0) begin
            hold_clr_s   = 1'b1;
            state_next_s = OWS_HOLD;
          end else begin
            state_next_s = OWS_DRAIN;
          end
        end else begin
          ch_en_s      = advance_s;
          state_next_s = OWS_WRITE;
        end
      end
      OWS_HOLD: begin
        hold_en_s = 1'b1;
        if (hold_last_s) begin
          state_next_s = OWS_DRAIN;
        end else begin
          state_next_s = OWS_HOLD;
        end
      end
      OWS_DRAIN: begin
        if (!done) begin
          state_next_s = OWS_IDLE;
        end else begin
          state_next_s = OWS_DRAIN;
        end
      end
      default: begin
        busy         = 1'b0;
        ch_clr_s     = 1'b1;
        hold_clr_s   = 1'b1;
        state_next_s = OWS_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_output_write_sequencer.sv
// Bench for output_write_sequencer: two builds (hold 5 and hold 0) driven in
// parallel, checked every cycle against a phase-level model plus fixed counts.
module tb_output_write_sequencer;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done;
  logic       ready;
  logic [3:0] ch_mask;
  logic       stall_clr;

  logic [1:0] wen_d, stall_d, busy_d, bd_d;
  logic [1:0] wch0_d, wch1_d;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  output_write_sequencer #(.NUM_CH(NCH), .HOLD_CYCLES(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .done(done), .ready(ready), .ch_mask(ch_mask),
    .stall_clr(stall_clr), .w_en(wen_d[0]), .w_ch(wch0_d), .stall(stall_d[0]),
    .busy(busy_d[0]), .burst_done(bd_d[0])
  );

  output_write_sequencer #(.NUM_CH(NCH), .HOLD_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .done(done), .ready(ready), .ch_mask(ch_mask),
    .stall_clr(stall_clr), .w_en(wen_d[1]), .w_ch(wch1_d), .stall(stall_d[1]),
    .busy(busy_d[1]), .burst_done(bd_d[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle-armed, 1 writing channels, 2 quiet interval, 3 waiting for done low.
  int         m_mode [2];
  int         m_pos  [2];
  int         m_left [2];
  logic [3:0] m_mask [2];

  function automatic int hold_of(input int b);
    return (b == 0) ? 5 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int b = 0; b < 2; b++) begin
      if (!rst_n) begin
        m_mode[b] <= 0;
        m_pos[b]  <= 0;
        m_left[b] <= 0;
        m_mask[b] <= 4'h0;
      end else begin
        case (m_mode[b])
          0: if (done) begin
            m_mask[b] <= ch_mask;
            m_pos[b]  <= 0;
            m_mode[b] <= 1;
          end
          1: if (ready || !m_mask[b][m_pos[b]]) begin
            if (m_pos[b] == NCH - 1) begin
              m_pos[b] <= 0;
              if (hold_of(b) > 0) begin
                m_mode[b] <= 2;
                m_left[b] <= hold_of(b);
              end else begin
                m_mode[b] <= 3;
              end
            end else begin
              m_pos[b] <= m_pos[b] + 1;
            end
          end
          2: begin
            m_left[b] <= m_left[b] - 1;
            if (m_left[b] == 1) m_mode[b] <= 3;
          end
          default: if (!done) m_mode[b] <= 0;
        endcase
      end
    end
  end

  // Packed as {busy, burst_done, stall, w_en, w_ch[1:0]}.
  function automatic logic [5:0] model_out(input int b);
    logic on;
    logic [5:0] r;
    r = 6'd0;
    case (m_mode[b])
      0: r[3] = done & ~stall_clr;
      1: begin
        on     = m_mask[b][m_pos[b]];
        r[5]   = 1'b1;
        r[4]   = (ready | ~on) && (m_pos[b] == NCH - 1);
        r[3]   = ~stall_clr;
        r[2]   = ready & on;
        r[1:0] = 2'(m_pos[b]);
      end
      default: r[5] = 1'b1;
    endcase
    return r;
  endfunction

  int n_wen0 = 0, n_sum0 = 0, n_bd0 = 0, n_stall0 = 0, n_busy0 = 0, n_busy1 = 0, n_wen1 = 0;
  int s_wen0, s_sum0, s_bd0, s_stall0, s_busy0, s_busy1, s_wen1;

  // Per-cycle comparison against the model, plus running event counts.
  always @(negedge clk) begin
    chk("cyc_b0", int'({busy_d[0], bd_d[0], stall_d[0], wen_d[0], wch0_d}), int'(model_out(0)));
    chk("cyc_b1", int'({busy_d[1], bd_d[1], stall_d[1], wen_d[1], wch1_d}), int'(model_out(1)));
    if (wen_d[0]) begin
      n_wen0 = n_wen0 + 1;
      n_sum0 = n_sum0 + int'(wch0_d);
    end
    if (wen_d[1]) n_wen1 = n_wen1 + 1;
    if (bd_d[0]) n_bd0 = n_bd0 + 1;
    if (stall_d[0]) n_stall0 = n_stall0 + 1;
    if (busy_d[0]) n_busy0 = n_busy0 + 1;
    if (busy_d[1]) n_busy1 = n_busy1 + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_wen0 = n_wen0; s_sum0 = n_sum0; s_bd0 = n_bd0; s_stall0 = n_stall0;
    s_busy0 = n_busy0; s_busy1 = n_busy1; s_wen1 = n_wen1;
  endtask

  task automatic pulse(input logic [3:0] m);
    done = 1'b1;
    ch_mask = m;
    step(1);
    done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; done = 1'b0; ready = 1'b0; ch_mask = 4'h0; stall_clr = 1'b0;
    step(3);
    chk("reset_busy", int'(busy_d), 0);
    chk("reset_wen", int'(wen_d), 0);
    chk("reset_stall", int'(stall_d), 0);
    chk("reset_wch", int'(wch0_d), 0);
    rst_n = 1'b1;
    ready = 1'b1;
    step(1);

    snap(); pulse(4'hF); step(15);
    chk("full_wen", n_wen0 - s_wen0, 4);
    chk("full_wch_sum", n_sum0 - s_sum0, 6);
    chk("full_burst_done", n_bd0 - s_bd0, 1);
    chk("full_stall", n_stall0 - s_stall0, 5);
    chk("full_busy_h5", n_busy0 - s_busy0, 10);
    chk("full_busy_h0", n_busy1 - s_busy1, 5);

    snap(); pulse(4'hA); step(15);
    chk("mask_a_wen", n_wen0 - s_wen0, 2);
    chk("mask_a_wch_sum", n_sum0 - s_sum0, 4);
    chk("mask_a_stall", n_stall0 - s_stall0, 5);
    chk("mask_a_busy", n_busy0 - s_busy0, 10);

    snap(); pulse(4'h0); step(15);
    chk("mask_0_wen", n_wen0 - s_wen0, 0);
    chk("mask_0_burst_done", n_bd0 - s_bd0, 1);

    snap(); pulse(4'hF); step(2);
    ready = 1'b0;
    step(3);
    ready = 1'b1;
    step(15);
    chk("stallrdy_wen", n_wen0 - s_wen0, 4);
    chk("stallrdy_stall", n_stall0 - s_stall0, 8);
    chk("stallrdy_busy", n_busy0 - s_busy0, 13);

    snap(); done = 1'b1; ch_mask = 4'hF; step(20); done = 1'b0; step(12);
    chk("held_burst_done", n_bd0 - s_bd0, 1);
    chk("held_wen", n_wen0 - s_wen0, 4);
    chk("held_busy_h5", n_busy0 - s_busy0, 20);
    chk("held_busy_h0", n_busy1 - s_busy1, 20);
    snap(); pulse(4'hF); step(15);
    chk("rearm_burst_done", n_bd0 - s_bd0, 1);
    chk("rearm_wen", n_wen0 - s_wen0, 4);

    stall_clr = 1'b1;
    snap(); pulse(4'hF); step(15);
    stall_clr = 1'b0;
    chk("clr_stall", n_stall0 - s_stall0, 0);
    chk("clr_wen", n_wen0 - s_wen0, 4);
    chk("clr_wch_sum", n_sum0 - s_sum0, 6);

    pulse(4'hF); step(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy_d), 0);
    chk("midrst_wen", int'(wen_d), 0);
    chk("midrst_stall", int'(stall_d), 0);
    chk("midrst_wch", int'({wch1_d, wch0_d}), 0);
    step(2);
    rst_n = 1'b1;
    snap(); step(10);
    chk("postrst_wen", (n_wen0 - s_wen0) + (n_wen1 - s_wen1), 0);
    chk("postrst_busy", n_busy0 - s_busy0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) done = ~done;
      ready     = ($urandom_range(0, 3) != 0);
      ch_mask   = 4'($urandom);
      stall_clr = ($urandom_range(0, 9) == 0);
      rst_n     = ($urandom_range(0, 399) != 0);
      step(1);
    end
    rst_n = 1'b1; done = 1'b0; stall_clr = 1'b0;
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_write_sequencer.md
Name: output_write_sequencer

Overview:
- Parametrised successor to the single-word output write controller.
- Sits between the PE-array "done" signal and the output buffer write port.
- On done: stalls the datapath and issues one write per enabled output channel (per-channel mask), honouring buffer ready back-pressure.
- Then a programmable hold interval, then waits for done to drop before re-arming.

Parameters:
- NUM_CH, 4, number of output channels/words written per done event (>=1)
- CH_W, $clog2(NUM_CH) (min 1), width of channel index
- HOLD_CYCLES, 5, post-burst quiet cycles before re-arm (0 allowed)
- HOLD_W, $clog2(HOLD_CYCLES+1) (min 1), hold counter width

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- done  in  1  compute-complete level from PE array.
- ready  in  1  output buffer can accept a write this cycle.
- ch_mask  in  NUM_CH  per-channel write enable; sampled when done is accepted.
- stall_clr  in  1  override, forces stall low (window-shift clear).
- w_en  out  1  output buffer write strobe.
- w_ch  out  CH_W  channel index of the current write.
- stall  out  1  datapath stall request.
- busy  out  1  high in any state other than IDLE.
- burst_done  out  1  one-cycle pulse when the last channel is retired.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ch_cnt=0, hold_cnt=0, mask_q=0.
  - All outputs 0; w_ch=0.
- States: IDLE, WRITE, HOLD, DRAIN. Encoding is registered; outputs are decoded combinationally from state, counters and inputs.
- IDLE:
  - When done=1: capture mask_q<=ch_mask, ch_cnt<=0, go to WRITE.
  - Otherwise stay.
- WRITE:
  - w_ch=ch_cnt.
  - w_en = ready & mask_q[ch_cnt].
  - Advance when (ready & mask_q[ch_cnt]) | ~mask_q[ch_cnt].
    - A masked channel consumes exactly one cycle with w_en=0, independent of ready.
    - An enabled channel waits indefinitely for ready and emits exactly one w_en cycle.
  - On advance with ch_cnt<NUM_CH-1: ch_cnt++.
  - On advance with ch_cnt==NUM_CH-1: burst_done=1 this cycle, ch_cnt<=0, next state HOLD (hold_cnt<=0) if HOLD_CYCLES>0, else DRAIN.
- HOLD:
  - hold_cnt increments each cycle.
  - Leave to DRAIN in the cycle hold_cnt==HOLD_CYCLES-1, giving exactly HOLD_CYCLES cycles in HOLD.
  - done is ignored.
- DRAIN:
  - Stay while done=1; go to IDLE the cycle after done=0 is seen.
  - Guarantees exactly one burst per done assertion (level-held done is not re-triggered).
- stall:
  - stall_clr=1 forces 0 (highest priority).
  - Otherwise 1 when (state==IDLE & done) or state==WRITE; 0 in HOLD/DRAIN.
  - The combinational IDLE term raises stall in the same cycle done first rises.
- busy = (state!=IDLE).
- Latency: done rising in IDLE at cycle t -> first possible w_en at t+1 (if ready and mask_q[0]=1).
  - Minimum burst length is NUM_CH cycles.
- ch_mask=0: NUM_CH cycles in WRITE, zero w_en, burst_done still pulses.
- ready dropping mid-burst: ch_cnt holds, w_en=0, stall stays 1; resume on the same channel.
- done dropping during WRITE/HOLD: burst completes regardless; DRAIN exits after one cycle.
- stall_clr affects stall only, never state or w_en.
- Reset mid-burst: immediate return to IDLE, no further writes, partial burst abandoned.
- Unreachable state encodings decode to IDLE behaviour and transition to IDLE.

Decomposition:
- Shared package `ows_pkg`: state encoding constants (OWS_IDLE, OWS_WRITE, OWS_HOLD, OWS_DRAIN) and a clog2-min-1 helper function for CH_W/HOLD_W.
- One natural sub-module: `ows_counter` (parametrised width, clear/enable/terminal-value flag), instantiated twice for ch_cnt and hold_cnt.

Test Plan:
- NUM_CH=4, mask=4'b1111, ready=1, done pulsed 1 cycle:
  - w_en high 4 consecutive cycles with w_ch=0,1,2,3.
  - burst_done with w_ch=3.
  - stall high from done cycle through w_ch=3, then 0.
  - busy drops after 5 HOLD cycles plus 1 DRAIN cycle.
- mask=4'b1010, ready=1: w_en only at w_ch=1 and w_ch=3; WRITE lasts exactly 4 cycles.
- mask=4'b1111, ready low 3 cycles while w_ch=2:
  - w_en=0 and w_ch stays 2 for those 3 cycles, stall=1.
  - Exactly 4 total w_en pulses.
- done held high for 20 cycles:
  - Exactly one burst.
  - FSM sits in DRAIN until done falls, then IDLE.
  - A new done pulse starts a second burst.
- stall_clr=1 during WRITE: stall=0 while w_en/w_ch sequencing is unchanged.
- rst_n asserted at w_ch=1 mid-burst: all outputs 0 immediately; after release, no writes until the next done.
- HOLD_CYCLES=0 build: WRITE -> DRAIN directly; burst_done is followed by IDLE the cycle after done=0.
